// File: rtl/caption_overlay_ctl_pkg.sv
// caption_overlay_ctl_pkg: caption geometry, display state encoding and default colours
package caption_overlay_ctl_pkg;
    localparam int CAP_W_DEF = 344;
    localparam int CAP_H_DEF = 64;
    localparam int ROM_DEPTH = CAP_W_DEF * CAP_H_DEF;
    localparam int ROM_AW = $clog2(ROM_DEPTH);
    localparam logic [11:0] WIN_COLOR_DEF = 12'h0F0;
    localparam logic [11:0] LOSE_COLOR_DEF = 12'hF00;
    typedef enum logic [1:0] {HIDDEN, BLINK, SHOWN} cap_state_t;
    // row offset y*344 built as 256+64+16+8 so no multiplier is inferred
    function automatic logic [ROM_AW-1:0] mul_cap_w(input logic [5:0] y);
        return ROM_AW'({y, 8'd0}) + ROM_AW'({y, 6'd0}) + ROM_AW'({y, 4'd0}) + ROM_AW'({y, 3'd0});
    endfunction
endpackage

// File: rtl/caption_overlay_ctl_if.sv
// caption_overlay_ctl_if: VGA stream in/out, race events and caption ROM port
interface caption_overlay_ctl_if;
    import caption_overlay_ctl_pkg::*;
    logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
    logic hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_in, rgb_out;
    logic race_done, player_won, clear;
    logic [ROM_AW-1:0] rom_address;
    logic [1:0] pixel_bit;
    modport slave(
        input hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        input race_done, player_won, clear, pixel_bit,
        output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, rom_address
    );
    modport master(
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        output race_done, player_won, clear, pixel_bit,
        input hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, rom_address
    );
endinterface

// File: rtl/caption_overlay_ctl_fsm.sv
// caption_overlay_ctl_fsm: latches race events and runs the frame-synchronous blink/hold display
module caption_overlay_ctl_fsm
    import caption_overlay_ctl_pkg::*;
#(
    parameter int BLINK_FRAMES = 15,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    input  logic race_done,
    input  logic player_won,
    input  logic clear,
    output logic visible,
    output logic result
);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam int TW = $clog2(BLINK_TOGGLES + 1);
    cap_state_t state, state_n;
    logic [FW-1:0] frame_cnt, frame_cnt_n;
    logic [TW-1:0] toggle_cnt, toggle_cnt_n;
    logic visible_n, result_n, result_next, pend_show, pend_clear;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HIDDEN;
            frame_cnt <= '0;
            toggle_cnt <= '0;
            visible <= 1'b0;
            result <= 1'b0;
            result_next <= 1'b0;
            pend_show <= 1'b0;
            pend_clear <= 1'b0;
        end else begin
            state <= state_n;
            frame_cnt <= frame_cnt_n;
            toggle_cnt <= toggle_cnt_n;
            visible <= visible_n;
            result <= result_n;
            pend_clear <= clear | (pend_clear & ~frame_start);
            pend_show <= clear ? 1'b0 : race_done ? 1'b1 :
                         (frame_start && !pend_clear && state == HIDDEN) ? 1'b0 : pend_show;
            if (race_done && !clear) result_next <= player_won;
        end
    end
    always_comb begin
        state_n = state;
        frame_cnt_n = frame_cnt;
        toggle_cnt_n = toggle_cnt;
        visible_n = visible;
        result_n = result;
        if (frame_start) begin
            if (pend_clear) begin
                state_n = HIDDEN;
                frame_cnt_n = '0;
                toggle_cnt_n = '0;
                visible_n = 1'b0;
            end else begin
                case (state)
                    HIDDEN: if (pend_show) begin
                        state_n = BLINK;
                        result_n = result_next;
                        frame_cnt_n = '0;
                        toggle_cnt_n = '0;
                        visible_n = 1'b1;
                    end
                    BLINK: if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                        frame_cnt_n = '0;
                        toggle_cnt_n = toggle_cnt + 1'b1;
                        visible_n = ~visible;
                        if (toggle_cnt_n == TW'(BLINK_TOGGLES)) begin
                            state_n = SHOWN;
                            visible_n = 1'b1;
                        end
                    end else begin
                        frame_cnt_n = frame_cnt + 1'b1;
                    end
                    default: visible_n = 1'b1;
                endcase
            end
        end
    end
endmodule

// File: rtl/caption_overlay_ctl.sv
// caption_overlay_ctl: generates caption ROM addresses and overlays the win/lose bitmap
// on the VGA stream with a 3-cycle timing delay matching the ROM read latency.
module caption_overlay_ctl
    import caption_overlay_ctl_pkg::*;
#(
    parameter int XPOS = 340,
    parameter int YPOS = 100,
    parameter int CAP_W = CAP_W_DEF,
    parameter int CAP_H = CAP_H_DEF,
    parameter logic [11:0] WIN_COLOR = WIN_COLOR_DEF,
    parameter logic [11:0] LOSE_COLOR = LOSE_COLOR_DEF,
    parameter int BLINK_FRAMES = 15,
    parameter int BLINK_TOGGLES = 6
) (
    input logic clk,
    input logic rst,
    caption_overlay_ctl_if.slave bus
);
    typedef struct packed {
        logic [10:0] h, v;
        logic hs, vs, hb, vb;
        logic [11:0] rgb;
    } vga_t;
    localparam logic [10:0] X0 = 11'(XPOS);
    localparam logic [10:0] X1 = 11'(XPOS + CAP_W);
    localparam logic [10:0] Y0 = 11'(YPOS);
    localparam logic [10:0] Y1 = 11'(YPOS + CAP_H);
    vga_t s0, s1, s2;
    logic box0, box1, box2, frame_start, visible, result, pix_on;
    logic [8:0] x_rel;
    logic [5:0] y_rel;
    assign s0 = {bus.hcount_in, bus.vcount_in, bus.hsync_in, bus.vsync_in, bus.hblnk_in, bus.vblnk_in, bus.rgb_in};
    assign box0 = bus.hcount_in >= X0 && bus.hcount_in < X1 && bus.vcount_in >= Y0 && bus.vcount_in < Y1;
    assign x_rel = 9'(bus.hcount_in - X0);
    assign y_rel = 6'(bus.vcount_in - Y0);
    assign frame_start = bus.hcount_in == '0 && bus.vcount_in == '0;
    // pixel_bit lines up with stage 2 because the ROM answers one cycle after the address
    assign pix_on = visible && box2 && bus.pixel_bit[result] && !s2.hb && !s2.vb;
    caption_overlay_ctl_fsm #(
        .BLINK_FRAMES(BLINK_FRAMES),
        .BLINK_TOGGLES(BLINK_TOGGLES)
    ) u_fsm (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .race_done(bus.race_done),
        .player_won(bus.player_won),
        .clear(bus.clear),
        .visible(visible),
        .result(result)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            box1 <= 1'b0;
            box2 <= 1'b0;
            bus.rom_address <= '0;
            {bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out} <= '0;
            bus.rgb_out <= '0;
        end else begin
            s1 <= s0;
            s2 <= s1;
            box1 <= box0;
            box2 <= box1;
            bus.rom_address <= box0 ? mul_cap_w(y_rel) + ROM_AW'(x_rel) : '0;
            {bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out} <=
                {s2.h, s2.v, s2.hs, s2.vs, s2.hb, s2.vb};
            bus.rgb_out <= pix_on ? (result ? WIN_COLOR : LOSE_COLOR) : s2.rgb;
        end
    end
endmodule

// File: tb/tb_caption_overlay_ctl.sv
// tb_caption_overlay_ctl: scoreboard bench driving short synthetic frames through the overlay
module tb_caption_overlay_ctl;
    typedef struct packed {
        logic [10:0] h, v;
        logic hs, vs, hb, vb;
        logic [11:0] rgb;
    } pix_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic trk, t1, t2, t3, exp_vis, exp_res;
    logic [1:0] rom_pat;
    int total = 0;
    int bad = 0;
    pix_t pix_q[$];
    logic [14:0] addr_q[$];
    pix_t pe, pg;
    logic [14:0] ae;
    always #5 clk = ~clk;
    caption_overlay_ctl_if bus();
    caption_overlay_ctl dut(.clk(clk), .rst(rst), .bus(bus));
    // caption ROM stand-in: odd addresses hold the current pattern, even ones are blank
    always @(posedge clk) bus.pixel_bit <= bus.rom_address[0] ? rom_pat : 2'b00;
    always @(posedge clk or posedge rst) begin
        if (rst) {t1, t2, t3} <= 3'b000;
        else begin
            t1 <= trk;
            t2 <= t1;
            t3 <= t2;
        end
    end
    always @(negedge clk) begin
        if (t1) begin
            total++;
            if (addr_q.size() == 0) begin
                bad++;
                $display("FAIL addr: got=%0d with no expected entry", bus.rom_address);
            end else begin
                ae = addr_q.pop_front();
                if (bus.rom_address !== ae) begin
                    bad++;
                    $display("FAIL addr: got=%0d exp=%0d", bus.rom_address, ae);
                end
            end
        end
        if (t3) begin
            total++;
            pg = {bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out, bus.rgb_out};
            if (pix_q.size() == 0) begin
                bad++;
                $display("FAIL pix: got=%h with no expected entry", pg);
            end else begin
                pe = pix_q.pop_front();
                if (pg !== pe) begin
                    bad++;
                    $display("FAIL pix h=%0d v=%0d: got rgb=%h all=%h exp rgb=%h all=%h", pe.h, pe.v, pg.rgb, pg, pe.rgb, pe);
                end
            end
        end
    end
    task automatic px(input logic [10:0] h, input logic [10:0] v, input logic hb,
                      input logic rd, input logic won, input logic clr);
        int hi, vi;
        logic box, on;
        logic [14:0] a;
        logic [11:0] rgb;
        pix_t e;
        hi = int'(h);
        vi = int'(v);
        box = hi >= 340 && hi < 684 && vi >= 100 && vi < 164;
        a = box ? 15'((vi - 100) * 344 + (hi - 340)) : 15'd0;
        rgb = {h[5:0], v[5:0]} ^ 12'h5A5;
        on = exp_vis && box && !hb && a[0] && rom_pat[exp_res];
        e.h = h;
        e.v = v;
        e.hs = h[0];
        e.vs = v[0];
        e.hb = hb;
        e.vb = 1'b0;
        e.rgb = on ? (exp_res ? 12'h0F0 : 12'hF00) : rgb;
        bus.hcount_in = h;
        bus.vcount_in = v;
        bus.hsync_in = h[0];
        bus.vsync_in = v[0];
        bus.hblnk_in = hb;
        bus.vblnk_in = 1'b0;
        bus.rgb_in = rgb;
        bus.race_done = rd;
        bus.player_won = won;
        bus.clear = clr;
        trk = 1'b1;
        addr_q.push_back(a);
        pix_q.push_back(e);
        @(posedge clk);
        #1;
        bus.race_done = 1'b0;
        bus.clear = 1'b0;
    endtask
    task automatic idle(input int n);
        trk = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic frame_ev(input logic vis, input logic res, input logic rd, input logic won, input logic clr);
        exp_vis = vis;
        exp_res = res;
        px(11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        px(11'd339, 11'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        px(11'd340, 11'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        px(11'd341, 11'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        px(11'd501, 11'd120, 1'b1, rd, won, clr);
        px(11'd501, 11'd121, 1'b0, 1'b0, 1'b0, 1'b0);
        px(11'd683, 11'd163, 1'b0, 1'b0, 1'b0, 1'b0);
        px(11'd684, 11'd163, 1'b0, 1'b0, 1'b0, 1'b0);
        px(11'd341, 11'd99, 1'b0, 1'b0, 1'b0, 1'b0);
        px(11'd341, 11'd164, 1'b0, 1'b0, 1'b0, 1'b0);
        px(11'd10, 11'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        px(11'd11, 11'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic frame(input logic vis, input logic res);
        frame_ev(vis, res, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic chk_zero(input string name);
        logic [62:0] got;
        got = {bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out,
               bus.rgb_out, bus.rom_address};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL %s: outputs=%h exp=0", name, got);
        end
    endtask
    initial begin
        {bus.hcount_in, bus.vcount_in, bus.hsync_in, bus.vsync_in, bus.hblnk_in, bus.vblnk_in} = '0;
        bus.rgb_in = '0;
        {bus.race_done, bus.player_won, bus.clear} = 3'b000;
        trk = 1'b0;
        rom_pat = 2'b10;
        exp_vis = 1'b0;
        exp_res = 1'b0;
        #12 rst = 1'b1;
        #1 chk_zero("reset");
        idle(2);
        rst = 1'b0;
        frame(1'b0, 1'b0);
        for (int h = 336; h < 346; h++) px(11'(h), 11'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        // win result raised mid-frame: current frame untouched, blink starts next frame
        frame_ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int n = 1; n <= 92; n++) frame(n >= 91 || ((n - 1) / 15) % 2 == 0, 1'b1);
        frame_ev(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b1);
        frame_ev(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        frame(1'b0, 1'b1);
        frame(1'b0, 1'b1);
        rom_pat = 2'b01;
        frame_ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0);
        frame(1'b1, 1'b0);
        exp_vis = 1'b1;
        exp_res = 1'b0;
        px(11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        px(11'd341, 11'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        trk = 1'b0;
        addr_q.delete();
        pix_q.delete();
        #1 chk_zero("mid_reset");
        idle(2);
        rst = 1'b0;
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        idle(6);
        total++;
        if (pix_q.size() != 0 || addr_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pix left=%0d addr left=%0d exp 0", pix_q.size(), addr_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
